// File: rtl/control_sequencer.sv
// Hardwired control unit: steps through fetch and execute for register-register ALU
// instructions, decoding per-step datapath strobes from the current state and the IR.
module control_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] ir,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic        instr_done,
  output logic        halted,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t state_q, state_d;

  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        is_3reg, is_muldiv, is_unary, is_halt;
  logic [12:0] alu_sel;
  logic        op_en;
  logic        done;

  logic [15:0] rin_s, rout_s;
  logic        pc_out, mar_in, inc_pc, pc_in, rd, mdr_in, mdr_out, ir_in;
  logic        y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in, halted_s;

  logic unused_ir;
  assign unused_ir = ^ir[14:0];

  assign opcode = ir[31:27];
  assign ra     = ir[26:23];
  assign rb     = ir[22:19];
  assign rc     = ir[18:15];

  assign is_3reg   = (opcode >= OP_ADD) && (opcode <= OP_SHL);
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign is_halt   = (opcode == OP_HALT);

  // ALU select order: AND OR ADD SUB MUL DIV SHR SHRA SHL ROR ROL NEG NOT
  always_comb begin
    alu_sel = 13'b0;
    case (opcode)
      OP_AND:  alu_sel = 13'b1000000000000;
      OP_OR:   alu_sel = 13'b0100000000000;
      OP_ADD:  alu_sel = 13'b0010000000000;
      OP_SUB:  alu_sel = 13'b0001000000000;
      OP_MUL:  alu_sel = 13'b0000100000000;
      OP_DIV:  alu_sel = 13'b0000010000000;
      OP_SHR:  alu_sel = 13'b0000001000000;
      OP_SHRA: alu_sel = 13'b0000000100000;
      OP_SHL:  alu_sel = 13'b0000000010000;
      OP_ROR:  alu_sel = 13'b0000000001000;
      OP_ROL:  alu_sel = 13'b0000000000100;
      OP_NEG:  alu_sel = 13'b0000000000010;
      OP_NOT:  alu_sel = 13'b0000000000001;
      default: alu_sel = 13'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    rin_s     = 16'h0;
    rout_s    = 16'h0;
    pc_out    = 1'b0;
    mar_in    = 1'b0;
    inc_pc    = 1'b0;
    pc_in     = 1'b0;
    rd        = 1'b0;
    mdr_in    = 1'b0;
    mdr_out   = 1'b0;
    ir_in     = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    zlow_out  = 1'b0;
    zhigh_out = 1'b0;
    hi_in     = 1'b0;
    lo_in     = 1'b0;
    halted_s  = 1'b0;
    op_en     = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: state_d = run ? S_T0 : S_IDLE;
      S_T0: begin
        pc_out  = 1'b1;
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
        pc_in   = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        rd      = 1'b1;
        mdr_in  = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        if (is_3reg) begin
          rout_s  = 16'(1) << rb;
          y_in    = 1'b1;
          state_d = S_T4;
        end else if (is_muldiv) begin
          rout_s  = 16'(1) << ra;
          y_in    = 1'b1;
          state_d = S_T4;
        end else if (is_unary) begin
          rout_s  = 16'(1) << rb;
          op_en   = 1'b1;
          z_in    = 1'b1;
          state_d = S_T4;
        end else begin
          done = 1'b1;
        end
      end
      S_T4: begin
        if (is_3reg) begin
          rout_s  = 16'(1) << rc;
          op_en   = 1'b1;
          z_in    = 1'b1;
          state_d = S_T5;
        end else if (is_muldiv) begin
          rout_s  = 16'(1) << rb;
          op_en   = 1'b1;
          z_in    = 1'b1;
          state_d = S_T5;
        end else if (is_unary) begin
          zlow_out = 1'b1;
          rin_s    = 16'(1) << ra;
          done     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T5: begin
        if (is_3reg) begin
          zlow_out = 1'b1;
          rin_s    = 16'(1) << ra;
          done     = 1'b1;
        end else if (is_muldiv) begin
          zlow_out = 1'b1;
          lo_in    = 1'b1;
          state_d  = S_T6;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T6: begin
        if (is_muldiv) begin
          zhigh_out = 1'b1;
          hi_in     = 1'b1;
          done      = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT: halted_s = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // HALT finishes its T3 step like any other instruction but then parks.
    if (done) begin
      if (state_q == S_T3 && is_halt) state_d = S_HALT;
      else                            state_d = run ? S_T0 : S_IDLE;
    end
  end

  assign Rin      = rin_s;
  assign Rout     = rout_s;
  assign PCout    = pc_out;
  assign MARin    = mar_in;
  assign IncPC    = inc_pc;
  assign PCin     = pc_in;
  assign Read     = rd;
  assign MDRin    = mdr_in;
  assign MDRout   = mdr_out;
  assign IRin     = ir_in;
  assign Yin      = y_in;
  assign Zin      = z_in;
  assign Zlowout  = zlow_out;
  assign Zhighout = zhigh_out;
  assign HIin     = hi_in;
  assign LOin     = lo_in;
  assign {AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT} =
    op_en ? alu_sel : 13'b0;
  assign instr_done = done;
  assign halted     = halted_s;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: driver pushes the expected per-cycle output
// word, a negedge monitor pops and compares against the DUT outputs.
module tb_control_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic [31:0] ir;
  logic [15:0] Rin, Rout;
  logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  logic instr_done, halted;
  logic [3:0] state_dbg;

  control_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .ir(ir),
    .Rin(Rin), .Rout(Rout),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin),
    .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV),
    .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL),
    .NEG(NEG), .NOT(NOT),
    .instr_done(instr_done), .halted(halted), .state_dbg(state_dbg)
  );

  // Output word: {Rin, Rout, strobes[13:0], alu[12:0], instr_done, halted}
  localparam logic [13:0] S_PCOUT    = 14'h2000;
  localparam logic [13:0] S_MARIN    = 14'h1000;
  localparam logic [13:0] S_INCPC    = 14'h0800;
  localparam logic [13:0] S_PCIN     = 14'h0400;
  localparam logic [13:0] S_READ     = 14'h0200;
  localparam logic [13:0] S_MDRIN    = 14'h0100;
  localparam logic [13:0] S_MDROUT   = 14'h0080;
  localparam logic [13:0] S_IRIN     = 14'h0040;
  localparam logic [13:0] S_YIN      = 14'h0020;
  localparam logic [13:0] S_ZIN      = 14'h0010;
  localparam logic [13:0] S_ZLOWOUT  = 14'h0008;
  localparam logic [13:0] S_ZHIGHOUT = 14'h0004;
  localparam logic [13:0] S_HIIN     = 14'h0002;
  localparam logic [13:0] S_LOIN     = 14'h0001;

  localparam logic [12:0] A_NONE = 13'h0000;
  localparam logic [12:0] A_ADD  = 13'h0400;
  localparam logic [12:0] A_MUL  = 13'h0100;
  localparam logic [12:0] A_SHRA = 13'h0020;
  localparam logic [12:0] A_NEG  = 13'h0002;

  localparam logic [31:0] IR_SHRA = 32'h521B8000;  // SHRA R4,R3,R7
  localparam logic [31:0] IR_MUL  = 32'h80900000;  // MUL R1,R2
  localparam logic [31:0] IR_NEG  = 32'h8AB00000;  // NEG R5,R6
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_ADD  = 32'h18918000;  // ADD R1,R2,R3
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_UNK  = 32'hF8000000;  // opcode 11111, unlisted

  logic [60:0] exp_q[$];
  string       name_q[$];
  int          total;
  int          bad;
  logic [60:0] act;

  assign act = {Rin, Rout,
                PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
                Yin, Zin, Zlowout, Zhighout, HIin, LOin,
                AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
                instr_done, halted};

  function automatic logic [60:0] ev(input logic [15:0] rin, input logic [15:0] rout,
                                     input logic [13:0] s, input logic [12:0] a,
                                     input logic d, input logic h);
    return {rin, rout, s, a, d, h};
  endfunction

  task automatic check(input string name, input logic [60:0] got, input logic [60:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, want);
    end
  endtask

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [60:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, act, e);
    end
  end

  // driver tasks
  task automatic step(input string name, input logic r, input logic [31:0] i,
                      input logic [60:0] e);
    @(posedge clk);
    #1;
    run = r;
    ir  = i;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic fetch(input string tag, input logic [31:0] i);
    step({tag, "_t0"}, 1'b1, i, ev(16'h0, 16'h0, S_PCOUT | S_MARIN | S_INCPC | S_PCIN, A_NONE, 1'b0, 1'b0));
    step({tag, "_t1"}, 1'b0, i, ev(16'h0, 16'h0, S_READ | S_MDRIN, A_NONE, 1'b0, 1'b0));
    step({tag, "_t2"}, 1'b0, i, ev(16'h0, 16'h0, S_MDROUT | S_IRIN, A_NONE, 1'b0, 1'b0));
  endtask

  localparam logic [60:0] ZERO = 61'h0;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    run   = 1'b1;
    ir    = 32'h0;

    // reset held with run=1
    step("reset_hold0", 1'b1, 32'h0, ZERO);
    step("reset_hold1", 1'b1, 32'h0, ZERO);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run   = 1'b0;
    for (int k = 0; k < 10; k++) step("idle_run0", 1'b0, 32'h0, ZERO);

    // SHRA R4,R3,R7, run low through the body, high at done
    step("shra_idle", 1'b1, IR_SHRA, ZERO);
    fetch("shra", IR_SHRA);
    step("shra_t3", 1'b0, IR_SHRA, ev(16'h0, 16'h0008, S_YIN, A_NONE, 1'b0, 1'b0));
    step("shra_t4", 1'b0, IR_SHRA, ev(16'h0, 16'h0080, S_ZIN, A_SHRA, 1'b0, 1'b0));
    step("shra_t5", 1'b1, IR_SHRA, ev(16'h0010, 16'h0, S_ZLOWOUT, A_NONE, 1'b1, 1'b0));

    // MUL R1,R2 back to back
    fetch("mul", IR_MUL);
    step("mul_t3", 1'b1, IR_MUL, ev(16'h0, 16'h0002, S_YIN, A_NONE, 1'b0, 1'b0));
    step("mul_t4", 1'b1, IR_MUL, ev(16'h0, 16'h0004, S_ZIN, A_MUL, 1'b0, 1'b0));
    step("mul_t5", 1'b1, IR_MUL, ev(16'h0, 16'h0, S_ZLOWOUT | S_LOIN, A_NONE, 1'b0, 1'b0));
    step("mul_t6", 1'b1, IR_MUL, ev(16'h0, 16'h0, S_ZHIGHOUT | S_HIIN, A_NONE, 1'b1, 1'b0));

    // NEG R5,R6, run dropped at done -> IDLE
    fetch("neg", IR_NEG);
    step("neg_t3", 1'b1, IR_NEG, ev(16'h0, 16'h0040, S_ZIN, A_NEG, 1'b0, 1'b0));
    step("neg_t4", 1'b0, IR_NEG, ev(16'h0020, 16'h0, S_ZLOWOUT, A_NONE, 1'b1, 1'b0));
    step("neg_idle0", 1'b0, IR_NEG, ZERO);
    step("neg_idle1", 1'b0, IR_NEG, ZERO);

    // unlisted opcode then NOP: done at T3 only
    step("unk_idle", 1'b1, IR_UNK, ZERO);
    fetch("unk", IR_UNK);
    step("unk_t3", 1'b1, IR_UNK, ev(16'h0, 16'h0, 14'h0, A_NONE, 1'b1, 1'b0));
    fetch("nop", IR_NOP);
    step("nop_t3", 1'b0, IR_NOP, ev(16'h0, 16'h0, 14'h0, A_NONE, 1'b1, 1'b0));
    step("nop_idle", 1'b0, IR_NOP, ZERO);

    // HALT parks regardless of run
    step("halt_idle", 1'b1, IR_HALT, ZERO);
    fetch("halt", IR_HALT);
    step("halt_t3", 1'b1, IR_HALT, ev(16'h0, 16'h0, 14'h0, A_NONE, 1'b1, 1'b0));
    for (int k = 0; k < 4; k++)
      step("halt_hold", k[0], IR_HALT, ev(16'h0, 16'h0, 14'h0, A_NONE, 1'b0, 1'b1));
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("halt_reset_async", act, ZERO);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run   = 1'b0;
    step("post_halt_idle", 1'b0, IR_HALT, ZERO);

    // ADD R1,R2,R3 with async reset mid-T4
    step("add_idle", 1'b1, IR_ADD, ZERO);
    fetch("add", IR_ADD);
    step("add_t3", 1'b1, IR_ADD, ev(16'h0, 16'h0004, S_YIN, A_NONE, 1'b0, 1'b0));
    step("add_t4", 1'b1, IR_ADD, ev(16'h0, 16'h0008, S_ZIN, A_ADD, 1'b0, 1'b0));
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("add_reset_async", act, ZERO);
    @(posedge clk);
    #1;
    check("add_reset_at_edge", act, ZERO);
    reset = 1'b0;
    run   = 1'b1;
    exp_q.push_back(ZERO);
    name_q.push_back("add_restart_idle");
    fetch("add2", IR_ADD);
    step("add2_t3", 1'b1, IR_ADD, ev(16'h0, 16'h0004, S_YIN, A_NONE, 1'b0, 1'b0));
    step("add2_t4", 1'b1, IR_ADD, ev(16'h0, 16'h0008, S_ZIN, A_ADD, 1'b0, 1'b0));
    step("add2_t5", 1'b0, IR_ADD, ev(16'h0002, 16'h0, S_ZLOWOUT, A_NONE, 1'b1, 1'b0));
    step("add2_idle", 1'b0, IR_ADD, ZERO);

    @(posedge clk);
    @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: left=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
